// File: rtl/stream_cipher_engine.sv
// ---------------------------------------------------------------------------
// stream_cipher_engine : byte-stream rolling-key cipher with ciphertext chaining
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module stream_cipher_engine #(
  parameter int KEY_LEN = 4,
  parameter int MAX_LEN = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [8*KEY_LEN-1:0]         key,
  input  logic [7:0]                   iv,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [7:0]                   in_data,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(MAX_LEN+1)-1:0] msg_len,
  output logic                         len_err
);

  localparam int KIDX_W = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam int CNT_W  = $clog2(MAX_LEN + 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;

  logic [0:0]           state_q, state_d;
  logic                 mode_q, mode_d;
  logic [8*KEY_LEN-1:0] key_q, key_d;
  logic [7:0]           chain_q, chain_d;
  logic [KIDX_W-1:0]    kidx_q, kidx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 out_valid_q, out_valid_d;
  logic [7:0]           out_data_q, out_data_d;
  logic                 out_last_q, out_last_d;
  logic [CNT_W-1:0]     out_len_q, out_len_d;
  logic                 done_q, done_d;
  logic [CNT_W-1:0]     msg_len_q, msg_len_d;

  logic                 w_in_ready, w_accept, w_idle, w_trunc, w_end_msg, w_xfer_last;
  logic                 w_mode;
  logic [8*KEY_LEN-1:0] w_key;
  logic [7:0]           w_prev, w_key_byte, w_enc, w_dec, w_chain_nxt;
  logic [KIDX_W-1:0]    w_kidx, w_kidx_nxt;
  logic [CNT_W-1:0]     w_cnt;

  always_comb begin
    w_in_ready = !out_valid_q || out_ready;
    w_accept   = in_valid && w_in_ready;
    w_idle     = (state_q == S_IDLE);

    // A byte arriving in IDLE opens a message, so it uses the live mode/key/iv
    w_mode = w_idle ? mode : mode_q;
    w_key  = w_idle ? key  : key_q;
    w_prev = w_idle ? iv   : chain_q;
    w_kidx = w_idle ? '0   : kidx_q;
    w_cnt  = w_idle ? CNT_W'(1) : cnt_q + 1'b1;

    w_key_byte = '0;
    for (int k = 0; k < KEY_LEN; k++) begin
      if (w_kidx == KIDX_W'(k)) w_key_byte = w_key[8*k +: 8];
    end

    w_enc       = (in_data ^ w_key_byte) + w_prev;
    w_dec       = (in_data - w_prev) ^ w_key_byte;
    w_chain_nxt = w_mode ? in_data : w_enc;
    w_kidx_nxt  = (w_kidx == KIDX_W'(KEY_LEN - 1)) ? '0 : w_kidx + 1'b1;

    w_trunc     = (w_cnt == CNT_W'(MAX_LEN)) && !in_last;
    w_end_msg   = in_last || w_trunc;
    w_xfer_last = out_valid_q && out_ready && out_last_q;

    state_d     = state_q;
    mode_d      = mode_q;
    key_d       = key_q;
    chain_d     = chain_q;
    kidx_d      = kidx_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_len_d   = out_len_q;

    if (w_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = w_mode ? w_dec : w_enc;
      out_last_d  = w_end_msg;
      out_len_d   = w_cnt;
      if (w_end_msg) begin
        state_d = S_IDLE;
        chain_d = '0;
        kidx_d  = '0;
        cnt_d   = '0;
      end else begin
        state_d = S_ACTIVE;
        mode_d  = w_mode;
        key_d   = w_key;
        chain_d = w_chain_nxt;
        kidx_d  = w_kidx_nxt;
        cnt_d   = w_cnt;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    done_d    = w_xfer_last;
    msg_len_d = w_xfer_last ? out_len_q : msg_len_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      key_q       <= '0;
      chain_q     <= '0;
      kidx_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_len_q   <= '0;
      done_q      <= 1'b0;
      msg_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      key_q       <= key_d;
      chain_q     <= chain_d;
      kidx_q      <= kidx_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_len_q   <= out_len_d;
      done_q      <= done_d;
      msg_len_q   <= msg_len_d;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == S_ACTIVE) || out_valid_q;
  assign done      = done_q;
  assign msg_len   = msg_len_q;
  assign len_err   = w_accept && w_trunc;

endmodule

`default_nettype wire

// File: tb/tb_stream_cipher_engine.sv
// ---------------------------------------------------------------------------
// tb_stream_cipher_engine : directed bench, hand-computed cipher vectors
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_stream_cipher_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [15:0] key;
  logic [7:0]  iv;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy, done, len_err;
  logic [7:0]  out_data;
  logic [6:0]  msg_len;

  logic        t_in_ready, t_out_valid, t_out_last, t_busy, t_done, t_len_err;
  logic [7:0]  t_out_data;
  logic [2:0]  t_msg_len;

  stream_cipher_engine #(.KEY_LEN(2), .MAX_LEN(64)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .msg_len(msg_len), .len_err(len_err)
  );

  stream_cipher_engine #(.KEY_LEN(2), .MAX_LEN(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .mode(mode), .key(key), .iv(iv),
    .in_valid(in_valid), .in_ready(t_in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(t_out_valid), .out_ready(out_ready), .out_data(t_out_data), .out_last(t_out_last),
    .busy(t_busy), .done(t_done), .msg_len(t_msg_len), .len_err(t_len_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {last, data} of every output transfer, per instance
  logic [8:0] oq[$];
  logic [8:0] tq[$];
  int done_cnt = 0, done_cyc = 0, last_xfer_cyc = 0, lerr_cnt = 0;
  int t_done_cnt = 0, t_lerr_cnt = 0, t_lerr_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        oq.push_back({out_last, out_data});
        if (out_last) last_xfer_cyc = cyc;
      end
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
      if (in_valid && in_ready && len_err) lerr_cnt = lerr_cnt + 1;
      if (t_out_valid && out_ready) tq.push_back({t_out_last, t_out_data});
      if (t_done) t_done_cnt = t_done_cnt + 1;
      if (in_valid && t_in_ready && t_len_err) begin
        t_lerr_cnt = t_lerr_cnt + 1;
        t_lerr_cyc = cyc;
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int acc_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic chk_out(input string tag, input int idx, input logic [7:0] d, input logic l);
    if (idx < oq.size()) chk(tag, {23'd0, oq[idx]}, {23'd0, l, d});
    else chk(tag, 32'hDEAD, {23'd0, l, d});
  endtask

  task automatic chk_tout(input string tag, input int idx, input logic [7:0] d, input logic l);
    if (idx < tq.size()) chk(tag, {23'd0, tq[idx]}, {23'd0, l, d});
    else chk(tag, 32'hDEAD, {23'd0, l, d});
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    logic got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [7:0] pt[9];
  logic [7:0] ct[9];
  int d0, td0, l0, tl0, a2;

  initial begin
    pt = '{8'h41, 8'h41, 8'h41, 8'h42, 8'h42, 8'h42, 8'h43, 8'h43, 8'h43};
    ct = '{8'h40, 8'h83, 8'hC3, 8'h03, 8'h46, 8'h86, 8'hC8, 8'h09, 8'h4B};
    rst_n = 1'b0; mode = 1'b0; key = 16'h0201; iv = 8'h00;
    in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_msg_len", {25'd0, msg_len}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // encrypt "AAA"
    oq.delete(); d0 = done_cnt;
    send(8'h41, 1'b0);
    chk("enc_busy_active", {31'd0, busy}, 32'd1);
    send(8'h41, 1'b0);
    send(8'h41, 1'b1);
    drain();
    chk("enc_count", oq.size(), 32'd3);
    chk_out("enc_b0", 0, 8'h40, 1'b0);
    chk_out("enc_b1", 1, 8'h83, 1'b0);
    chk_out("enc_b2", 2, 8'hC3, 1'b1);
    chk("enc_done_cnt", done_cnt - d0, 32'd1);
    chk("enc_done_lat", done_cyc - last_xfer_cyc, 32'd1);
    chk("enc_msg_len", {25'd0, msg_len}, 32'd3);

    // decrypt back
    oq.delete(); mode = 1'b1;
    send(8'h40, 1'b0);
    send(8'h83, 1'b0);
    send(8'hC3, 1'b1);
    drain();
    chk("dec_count", oq.size(), 32'd3);
    chk_out("dec_b0", 0, 8'h41, 1'b0);
    chk_out("dec_b1", 1, 8'h41, 1'b0);
    chk_out("dec_b2", 2, 8'h41, 1'b1);

    // 9-byte round trip
    oq.delete(); mode = 1'b0;
    for (int i = 0; i < 9; i++) send(pt[i], (i == 8));
    drain();
    for (int i = 0; i < 9; i++) chk_out("rt_enc", i, ct[i], (i == 8));
    chk("rt_msg_len", {25'd0, msg_len}, 32'd9);
    oq.delete(); mode = 1'b1;
    for (int i = 0; i < 9; i++) send(ct[i], (i == 8));
    drain();
    for (int i = 0; i < 9; i++) chk_out("rt_dec", i, pt[i], (i == 8));

    // single byte, addition wraps mod 256
    oq.delete(); mode = 1'b0; iv = 8'hF0;
    send(8'h41, 1'b1);
    chk("wrap_busy_pending", {31'd0, busy}, 32'd1);
    drain();
    chk("wrap_count", oq.size(), 32'd1);
    chk_out("wrap_b0", 0, 8'h30, 1'b1);
    chk("wrap_busy_after", {31'd0, busy}, 32'd0);
    chk("wrap_msg_len", {25'd0, msg_len}, 32'd1);

    // backpressure
    oq.delete(); iv = 8'h00;
    send(8'h41, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h41; in_last = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {23'd0, out_valid, out_data}, {23'd0, 1'b1, 8'h40});
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(8'h41, 1'b0);
    a2 = acc_cyc;
    send(8'h41, 1'b1);
    chk("bp_rate", acc_cyc - a2, 32'd1);
    drain();
    chk("bp_count", oq.size(), 32'd3);
    chk_out("bp_b0", 0, 8'h40, 1'b0);
    chk_out("bp_b1", 1, 8'h83, 1'b0);
    chk_out("bp_b2", 2, 8'hC3, 1'b1);

    // truncation at MAX_LEN=4 on the second instance
    tq.delete(); td0 = t_done_cnt; tl0 = t_lerr_cnt; l0 = lerr_cnt;
    send(8'h41, 1'b0);
    send(8'h41, 1'b0);
    send(8'h41, 1'b0);
    send(8'h41, 1'b0);
    chk("trunc_lerr_cyc", acc_cyc - t_lerr_cyc, 32'd1);
    send(8'h41, 1'b0);
    chk("trunc_len4", {29'd0, t_msg_len}, 32'd4);
    send(8'h41, 1'b1);
    drain();
    chk("trunc_count", tq.size(), 32'd6);
    chk_tout("trunc_b0", 0, 8'h40, 1'b0);
    chk_tout("trunc_b1", 1, 8'h83, 1'b0);
    chk_tout("trunc_b2", 2, 8'hC3, 1'b0);
    chk_tout("trunc_b3", 3, 8'h06, 1'b1);
    chk_tout("trunc_b4", 4, 8'h40, 1'b0);
    chk_tout("trunc_b5", 5, 8'h83, 1'b1);
    chk("trunc_lerr_cnt", t_lerr_cnt - tl0, 32'd1);
    chk("trunc_done_cnt", t_done_cnt - td0, 32'd2);
    chk("trunc_msg_len2", {29'd0, t_msg_len}, 32'd2);
    chk("nontrunc_lerr", lerr_cnt - l0, 32'd0);

    // reset mid-message
    oq.delete();
    send(8'h41, 1'b0);
    d0 = done_cnt;
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_out_data", {24'd0, out_data}, 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_msg_len", {25'd0, msg_len}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h41, 1'b0);
    send(8'h41, 1'b1);
    drain();
    chk("mrst_count", oq.size(), 32'd2);
    chk_out("mrst_b0", 0, 8'h40, 1'b0);
    chk_out("mrst_b1", 1, 8'h83, 1'b1);
    chk("mrst_done_cnt", done_cnt - d0, 32'd1);
    chk("mrst_msg_len2", {25'd0, msg_len}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
